// File: rtl/mem_copy_engine.sv
// Word-block copy engine mastering the data-memory port: copies len words from
// src to dst, one READ cycle then one WRITE cycle per word, lowest address first.
module mem_copy_engine #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_i,
   input  logic [ADDR_W-1:0] dst_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [LEN_W-1:0]  count_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] WriteData_o,
   output logic              MemWrite_o,
   output logic              MemRead_o,
   input  logic [DATA_W-1:0] ReadData_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  count_d;
   logic [DATA_W-1:0] buf_q, buf_d;

   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              mem_write_d, mem_read_d, busy_d, done_d;

   // count_o doubles as the word index: it only ever advances on a completed WRITE.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      count_d     = count_o;
      buf_d       = buf_q;
      addr_d      = '0;
      wdata_d     = '0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               src_d   = src_i;
               dst_d   = dst_i;
               len_d   = len_i;
               count_d = '0;
               state_d = (len_i == '0) ? DONE : READ;
            end
         end
         READ: begin
            buf_d   = ReadData_i;
            state_d = WRITE;
         end
         WRITE: begin
            count_d = count_o + LEN_W'(1);
            state_d = (count_o + LEN_W'(1) == len_q) ? DONE : READ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus signals are decoded from the next state and registered, so the
      // level-sensitive memory never sees a combinational path from the inputs.
      case (state_d)
         READ: begin
            addr_d     = src_d + ADDR_W'(count_d);
            mem_read_d = 1'b1;
            busy_d     = 1'b1;
         end
         WRITE: begin
            addr_d      = dst_d + ADDR_W'(count_d);
            wdata_d     = buf_d;
            mem_write_d = 1'b1;
            busy_d      = 1'b1;
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst_i) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         count_o     <= '0;
         buf_q       <= '0;
         addr_o      <= '0;
         WriteData_o <= '0;
         MemWrite_o  <= 1'b0;
         MemRead_o   <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         count_o     <= count_d;
         buf_q       <= buf_d;
         addr_o      <= addr_d;
         WriteData_o <= wdata_d;
         MemWrite_o  <= mem_write_d;
         MemRead_o   <= mem_read_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a word-level forward-copy model queues the
// expected reads, writes and done counts; a negedge monitor pops and compares them.
module tb_mem_copy_engine;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i;
   logic [31:0] src_i, dst_i;
   logic [7:0]  len_i;
   logic        busy_o, done_o, MemWrite_o, MemRead_o;
   logic [7:0]  count_o;
   logic [31:0] addr_o, WriteData_o, ReadData_i;

   mem_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
      .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
      .addr_o(addr_o), .WriteData_o(WriteData_o), .MemWrite_o(MemWrite_o),
      .MemRead_o(MemRead_o), .ReadData_i(ReadData_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem     [logic [31:0]];   // memory seen by the DUT
   logic [31:0] ref_mem [logic [31:0]];   // reference model's memory
   logic [31:0] exp_rd   [$];
   logic [63:0] exp_wr   [$];
   logic [7:0]  exp_done [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name, input logic [63:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected activity %h, nothing expected at %0t", name, act, $time);
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   // Forward word copy: nr reads issued, the first nw words written.
   task automatic model(input logic [31:0] s, input logic [31:0] d, input int nr, input int nw);
      logic [31:0] v;
      for (int i = 0; i < nr; i++) exp_rd.push_back(s + 32'(i));
      for (int i = 0; i < nw; i++) begin
         v = ref_rd(s + 32'(i));
         ref_mem[d + 32'(i)] = v;
         exp_wr.push_back({d + 32'(i), v});
      end
   endtask

   // Memory environment: zero-latency read, write lands inside the WRITE cycle.
   always @(negedge clk_i) begin
      if (MemWrite_o === 1'b1) mem[addr_o] = WriteData_o;
      ReadData_i = (MemRead_o === 1'b1) ? mem_rd(addr_o) : 32'h0;
   end

   // Monitor
   always @(negedge clk_i) begin
      logic [31:0] ea;
      logic [63:0] ew;
      logic [7:0]  ec;
      if (MemRead_o === 1'b1 && MemWrite_o === 1'b1) flag("rd_wr_overlap", {addr_o, WriteData_o});
      if (busy_o === 1'b0) begin
         check("idle_bus", {addr_o, WriteData_o}, 64'h0);
         check("idle_en", {MemRead_o, MemWrite_o}, 64'h0);
      end
      if (MemRead_o === 1'b1) begin
         if (exp_rd.size() == 0) flag("read", {32'h0, addr_o});
         else begin
            ea = exp_rd.pop_front();
            check("read_addr", addr_o, ea);
         end
      end
      if (MemWrite_o === 1'b1) begin
         if (exp_wr.size() == 0) flag("write", {addr_o, WriteData_o});
         else begin
            ew = exp_wr.pop_front();
            check("write_addr_data", {addr_o, WriteData_o}, ew);
         end
      end
      if (done_o === 1'b1) begin
         if (exp_done.size() == 0) flag("done", {56'h0, count_o});
         else begin
            ec = exp_done.pop_front();
            check("done_count", count_o, ec);
         end
      end
   end

   // One full copy with timing checks; junk_cyc>0 pulses a conflicting start in that cycle.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len, input int junk_cyc);
      int cyc, busy_cnt, done_at;
      @(negedge clk_i);
      src_i = s; dst_i = d; len_i = 8'(len); start_i = 1'b1;
      model(s, d, len, len);
      exp_done.push_back(8'(len));
      cyc = 1; busy_cnt = 0; done_at = 0;
      @(negedge clk_i);
      while (cyc <= 2 * len + 4 && done_at == 0) begin
         if (busy_o === 1'b1) busy_cnt++;
         if (done_o === 1'b1) done_at = cyc;
         if (cyc == junk_cyc) begin
            start_i = 1'b1; src_i = ~s; dst_i = s; len_i = 8'(len + 3);
         end else start_i = 1'b0;
         if (done_at == 0) begin
            @(negedge clk_i);
            cyc++;
         end
      end
      check("busy_cycles", busy_cnt, 2 * len);
      check("done_cycle", done_at, 2 * len + 1);
      @(negedge clk_i);
      start_i = 1'b0;
      check("after_done", {busy_o, done_o}, 64'h0);
      check("count_hold", count_o, len);
      @(negedge clk_i);
      check("still_idle", {busy_o, done_o}, 64'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s, d, len, junk;
      rst_i = 1'b1; start_i = 1'b1; src_i = 32'h0; dst_i = 32'h4; len_i = 8'd3;
      ReadData_i = 32'h0;

      // Reset held with start high: everything stays zero.
      repeat (2) begin
         @(negedge clk_i);
         check("rst_outs", {busy_o, done_o, count_o, MemWrite_o, MemRead_o}, 64'h0);
         check("rst_bus", {addr_o, WriteData_o}, 64'h0);
      end
      rst_i = 1'b0; start_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_idle", {busy_o, MemRead_o}, 64'h0);

      // Basic copy
      set_word(32'd0, 32'hA); set_word(32'd1, 32'hB); set_word(32'd2, 32'hC);
      run_copy(32'd0, 32'd4, 3, 0);
      check("basic_m4", mem_rd(32'd4), 32'hA);
      check("basic_m5", mem_rd(32'd5), 32'hB);
      check("basic_m6", mem_rd(32'd6), 32'hC);
      check("basic_m3", mem_rd(32'd3), init_val(32'd3));
      check("basic_m7", mem_rd(32'd7), init_val(32'd7));

      // Zero length
      run_copy(32'd10, 32'd20, 0, 0);
      check("zero_count", count_o, 8'd0);

      // Overlapping forward copy
      for (int i = 0; i < 4; i++) set_word(32'(i), 32'(i + 1));
      run_copy(32'd0, 32'd1, 3, 0);
      for (int i = 0; i < 4; i++) check("overlap", mem_rd(32'(i)), 32'd1);

      // Start while busy, then a start pulse during DONE
      run_copy(32'd30, 32'd40, 2, 2);
      run_copy(32'd41, 32'd50, 3, 7);

      // Reset mid-copy during the second READ
      set_word(32'd0, 32'h11); set_word(32'd1, 32'h22); set_word(32'd2, 32'h33);
      set_word(32'd4, 32'hF0); set_word(32'd5, 32'hF1); set_word(32'd6, 32'hF2);
      @(negedge clk_i);
      src_i = 32'd0; dst_i = 32'd4; len_i = 8'd3; start_i = 1'b1;
      model(32'd0, 32'd4, 2, 1);
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_outs", {busy_o, done_o, count_o, MemWrite_o, MemRead_o}, 64'h0);
      check("midrst_bus", {addr_o, WriteData_o}, 64'h0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("midrst_m4", mem_rd(32'd4), 32'h11);
      check("midrst_m5", mem_rd(32'd5), 32'hF1);
      check("midrst_m6", mem_rd(32'd6), 32'hF2);
      run_copy(32'd0, 32'd4, 3, 0);
      check("recover_m6", mem_rd(32'd6), 32'h33);

      // Address wrap-around
      run_copy(32'hFFFF_FFFE, 32'hFFFF_FFFF, 4, 0);

      // Randomized copies
      for (int k = 0; k < 24; k++) begin
         s    = $urandom_range(0, 63);
         d    = $urandom_range(0, 63);
         len  = $urandom_range(0, 12);
         junk = (k % 3 == 0) ? $urandom_range(1, 2 * len + 1) : 0;
         run_copy(32'(s), 32'(d), len, junk);
      end

      // Memory image against the model
      for (int a = 0; a < 80; a++) check("mem_image", mem_rd(32'(a)), ref_rd(32'(a)));
      for (int a = 0; a < 16; a++)
         check("mem_image_hi", mem_rd(32'hFFFF_FFF0 + 32'(a)), ref_rd(32'hFFFF_FFF0 + 32'(a)));
      check("queues_empty", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
